div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Sequences EXE-stage div.w/mod.w/div.wu/mod.wu onto the signed and unsigned divider IP
//  cores (AXI-stream dividend/divisor in, 64-bit {quot,rem} out). Latches the operands and
//  drives each input channel independently until its handshake completes. Waits for dout,
//  then holds the selected 32-bit result for EXE. Flushes (wb_ex/ertn) never break the IP
//  handshake: an in-flight op is drained and its result is discarded.
// PARAMETERS
//  DATA_W  32  operand/result width; dout is 2*DATA_W = {quot,rem}
// PORTS
//  clk            in   1        single clock, rising edge
//  resetn         in   1        asynchronous, active-low reset
//  flush          in   1        wb_ex|wb_ertn; kills the current/incoming op
//  req_valid      in   1        EXE presents a divide op
//  req_ready      out  1        controller accepts a request (state IDLE)
//  req_signed     in   1        1: div.w/mod.w, 0: div.wu/mod.wu
//  req_mod        in   1        1: return remainder, 0: return quotient
//  req_src1       in   DATA_W   dividend
//  req_src2       in   DATA_W   divisor
//  resp_valid     out  1        result ready for EXE (es_ready_go term)
//  resp_ready     in   1        EXE consumes the result (es_ready_go & ms_allowin)
//  resp_data      out  DATA_W   quotient or remainder
//  s_dvd_tvalid   out  2        dividend tvalid, [1]=signed IP, [0]=unsigned IP
//  s_dvd_tready   in   2        dividend tready, same indexing
//  s_dvs_tvalid   out  2        divisor tvalid, same indexing
//  s_dvs_tready   in   2        divisor tready, same indexing
//  s_dvd_tdata    out  DATA_W   latched dividend, shared by both IPs
//  s_dvs_tdata    out  DATA_W   latched divisor, shared by both IPs
//  m_dout_tvalid  in   2        result valid from each IP
//  m_dout_tdata   in   4*DATA_W {signed{q,r}, unsigned{q,r}}
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE; all tvalid=0; resp_valid=0; resp_data=0; sent flags=0.
//  req_ready = (state==IDLE) & ~flush. Accept = req_valid & req_ready.
//  On accept: latch src1/src2/signed/mod; tdata ports come from the latches and stay stable.
//  States:
//   IDLE  - accept -> ISSUE.
//   ISSUE - tvalid[sel]=1 on each channel whose sent flag is clear. A channel's sent flag
//           sets on tvalid&tready. The two channels may complete in different cycles or the
//           same cycle. Both sent -> WAIT (tvalid drops in that cycle). flush -> DRAIN.
//   WAIT  - m_dout_tvalid[sel] -> DONE, capturing q or r into resp_data. flush -> DRAIN.
//   DONE  - resp_valid=1. resp_ready -> IDLE. flush -> IDLE with no response.
//   DRAIN - keep driving any unsent channel until its handshake completes (AXI: tvalid never
//           retracts). Then wait for m_dout_tvalid[sel], discard the result, -> IDLE.
//           resp_valid stays 0. A further flush has no effect.
//  Only tvalid[sel] is ever driven. The unselected IP index stays 0.
//  flush takes priority over every other transition in the same cycle. flush & req_valid in
//  IDLE means no accept.
//  Minimum latency, accept to resp_valid: 1 (ISSUE) + IP latency + 1 (capture) cycles.
//  resp_valid is registered, with no combinational path from m_dout_tvalid.
//  Divide-by-zero and overflow: the IP's raw dout is forwarded unmodified.
//  Reset mid-op: everything returns to the reset state. The IP cores share resetn, so no
//  drain is needed.
//  At most one op is in flight. req_ready=0 in every state except IDLE.
// TESTING
//  1 div.w -7/2, both treadys high: ISSUE 1 cycle, IP returns {-3,-1} -> resp_data=0xFFFFFFFD.
//  2 mod.wu 0xFFFFFFFF/0x10, dvd tready at cycle+1 and dvs tready at cycle+3: each tvalid
//    drops only after its own handshake -> resp_data=0xF.
//  3 Flush in ISSUE with the divisor unsent: divisor tvalid held until tready, then dout is
//    discarded, resp_valid never rises, and req_ready returns after the dout beat.
//  4 Flush while in DONE with resp_ready=0: next cycle IDLE, resp_valid=0. A new div.w 10/3
//    then returns 3.
//  5 resetn pulsed low mid-WAIT, asynchronously: all outputs are 0 immediately and req_ready=1
//    after release.
//  6 Back-to-back div.w 100/7 then mod.w 100/7, with resp_ready held high -> 14 then 2. The
//    unselected tvalid stays 0 throughout.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue controller for the signed/unsigned divider IP cores used by div.w/mod.w/div.wu/mod.wu.
// Holds the operands, completes each AXI-stream input handshake, and returns the chosen half of dout.
module div_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_signed,
    input  logic                  req_mod,
    input  logic [DATA_W-1:0]     req_src1,
    input  logic [DATA_W-1:0]     req_src2,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    output logic [1:0]            s_dvd_tvalid,
    input  logic [1:0]            s_dvd_tready,
    output logic [1:0]            s_dvs_tvalid,
    input  logic [1:0]            s_dvs_tready,
    output logic [DATA_W-1:0]     s_dvd_tdata,
    output logic [DATA_W-1:0]     s_dvs_tdata,
    input  logic [1:0]            m_dout_tvalid,
    input  logic [4*DATA_W-1:0]   m_dout_tdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [DATA_W-1:0]   dvd_q;
    logic [DATA_W-1:0]   dvs_q;
    logic                sel;
    logic                mod_q;
    logic                dvd_sent;
    logic                dvs_sent;

    logic                accept;
    logic                issuing;
    logic                dvd_drive;
    logic                dvs_drive;
    logic                dvd_fire;
    logic                dvs_fire;
    logic                dvd_done;
    logic                dvs_done;
    logic                dout_fire;
    logic [2*DATA_W-1:0] dout_word;
    logic [DATA_W-1:0]   result;

    assign req_ready = (state == S_IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    // A channel keeps tvalid up until its own handshake, also while draining a flushed op.
    assign issuing      = (state == S_ISSUE) || (state == S_DRAIN);
    assign dvd_drive    = issuing && !dvd_sent;
    assign dvs_drive    = issuing && !dvs_sent;
    assign s_dvd_tvalid = {dvd_drive && sel, dvd_drive && !sel};
    assign s_dvs_tvalid = {dvs_drive && sel, dvs_drive && !sel};
    assign dvd_fire     = dvd_drive && s_dvd_tready[sel];
    assign dvs_fire     = dvs_drive && s_dvs_tready[sel];
    assign dvd_done     = dvd_sent || dvd_fire;
    assign dvs_done     = dvs_sent || dvs_fire;
    assign s_dvd_tdata  = dvd_q;
    assign s_dvs_tdata  = dvs_q;

    assign dout_fire = m_dout_tvalid[sel];
    assign dout_word = sel ? m_dout_tdata[4*DATA_W-1:2*DATA_W] : m_dout_tdata[2*DATA_W-1:0];
    assign result    = mod_q ? dout_word[DATA_W-1:0] : dout_word[2*DATA_W-1:DATA_W];

    // NOTE: state_nxt gets its default before the case so no path can leave it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (flush)                     state_nxt = S_DRAIN;
                else if (dvd_done && dvs_done) state_nxt = S_WAIT;
            end
            // A flush coinciding with the dout beat has nothing left to drain.
            S_WAIT: begin
                if (flush)          state_nxt = dout_fire ? S_IDLE : S_DRAIN;
                else if (dout_fire) state_nxt = S_DONE;
            end
            S_DONE:  if (flush || resp_ready) state_nxt = S_IDLE;
            S_DRAIN: if (dvd_sent && dvs_sent && dout_fire) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            sel        <= 1'b0;
            mod_q      <= 1'b0;
            dvd_sent   <= 1'b0;
            dvs_sent   <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            state      <= state_nxt;
            resp_valid <= (state_nxt == S_DONE);
            if (accept) begin
                dvd_q    <= req_src1;
                dvs_q    <= req_src2;
                sel      <= req_signed;
                mod_q    <= req_mod;
                dvd_sent <= 1'b0;
                dvs_sent <= 1'b0;
            end else begin
                if (dvd_fire) dvd_sent <= 1'b1;
                if (dvs_fire) dvs_sent <= 1'b1;
            end
            if ((state == S_WAIT) && dout_fire && !flush) resp_data <= result;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider IP model, protocol monitor and directed/random ops.
module tb_div_issue_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           resetn;
    logic           flush;
    logic           req_valid;
    logic           req_ready;
    logic           req_signed;
    logic           req_mod;
    logic [W-1:0]   req_src1;
    logic [W-1:0]   req_src2;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_data;
    logic [1:0]     s_dvd_tvalid;
    logic [1:0]     s_dvd_tready;
    logic [1:0]     s_dvs_tvalid;
    logic [1:0]     s_dvs_tready;
    logic [W-1:0]   s_dvd_tdata;
    logic [W-1:0]   s_dvs_tdata;
    logic [1:0]     m_dout_tvalid;
    logic [4*W-1:0] m_dout_tdata;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ready_mode;     // 0: fixed per-channel tready delays, 1: random tready
    int   dvd_delay;
    int   dvs_delay;
    int   ip_lat;
    logic cur_signed;
    bit   expect_no_resp;

    div_issue_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed), .req_mod(req_mod),
        .req_src1(req_src1), .req_src2(req_src2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .s_dvd_tvalid(s_dvd_tvalid), .s_dvd_tready(s_dvd_tready),
        .s_dvs_tvalid(s_dvs_tvalid), .s_dvs_tready(s_dvs_tready),
        .s_dvd_tdata(s_dvd_tdata), .s_dvs_tdata(s_dvs_tdata),
        .m_dout_tvalid(m_dout_tvalid), .m_dout_tdata(m_dout_tdata)
    );

    always #5 clk = ~clk;

    // Architectural divide: truncating quotient, remainder takes the dividend's sign.
    function automatic logic [2*W-1:0] ref_qr(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    function automatic logic [W-1:0] ref_result(input logic sgn, input logic md, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] qr;
        qr = ref_qr(sgn, a, b);
        return md ? qr[W-1:0] : qr[2*W-1:W];
    endfunction

    // Divider IP pair model plus AXI-stream monitor; samples on negedge, drives at posedge+1.
    initial begin
        int         dvd_cnt;
        int         dvs_cnt;
        logic [1:0] hs_dvd;
        logic [1:0] hs_dvs;
        logic [1:0] pend_dvd;
        logic [1:0] pend_dvs;
        logic [1:0] unsel;
        logic [W-1:0] cap_dvd [2];
        logic [W-1:0] cap_dvs [2];
        bit         got_dvd [2];
        bit         got_dvs [2];
        bit         running [2];
        int         lat_cnt [2];
        dvd_cnt = 0; dvs_cnt = 0; pend_dvd = '0; pend_dvs = '0;
        for (int c = 0; c < 2; c++) begin
            got_dvd[c] = 0; got_dvs[c] = 0; running[c] = 0; lat_cnt[c] = 0;
            cap_dvd[c] = '0; cap_dvs[c] = '0;
        end
        s_dvd_tready = '0; s_dvs_tready = '0; m_dout_tvalid = '0; m_dout_tdata = '0;
        forever begin
            @(negedge clk);
            hs_dvd = s_dvd_tvalid & s_dvd_tready;
            hs_dvs = s_dvs_tvalid & s_dvs_tready;
            if (resetn) begin
                for (int c = 0; c < 2; c++) begin
                    if (pend_dvd[c]) begin
                        n_checks++;
                        if (!s_dvd_tvalid[c]) begin
                            n_fail++;
                            $display("FAIL dvd_tvalid_hold[%0d]: tvalid=0 before handshake, required 1", c);
                        end
                    end
                    if (pend_dvs[c]) begin
                        n_checks++;
                        if (!s_dvs_tvalid[c]) begin
                            n_fail++;
                            $display("FAIL dvs_tvalid_hold[%0d]: tvalid=0 before handshake, required 1", c);
                        end
                    end
                end
                unsel = cur_signed ? 2'b01 : 2'b10;
                n_checks++;
                if (((s_dvd_tvalid | s_dvs_tvalid) & unsel) !== 2'b00) begin
                    n_fail++;
                    $display("FAIL unselected_tvalid: dvd=%b dvs=%b, unselected index must stay 0",
                             s_dvd_tvalid, s_dvs_tvalid);
                end
                if (expect_no_resp) begin
                    n_checks++;
                    if (resp_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL no_resp: resp_valid=%b, required 0", resp_valid);
                    end
                end
            end
            pend_dvd = s_dvd_tvalid & ~s_dvd_tready;
            pend_dvs = s_dvs_tvalid & ~s_dvs_tready;
            for (int c = 0; c < 2; c++) begin
                if (hs_dvd[c]) begin cap_dvd[c] = s_dvd_tdata; got_dvd[c] = 1; end
                if (hs_dvs[c]) begin cap_dvs[c] = s_dvs_tdata; got_dvs[c] = 1; end
            end
            if (hs_dvd != 0) dvd_cnt = 0; else if (pend_dvd != 0) dvd_cnt++;
            if (hs_dvs != 0) dvs_cnt = 0; else if (pend_dvs != 0) dvs_cnt++;

            @(posedge clk);
            #1;
            m_dout_tvalid = '0;
            if (!resetn) begin
                for (int c = 0; c < 2; c++) begin
                    got_dvd[c] = 0; got_dvs[c] = 0; running[c] = 0;
                end
                pend_dvd = '0; pend_dvs = '0; dvd_cnt = 0; dvs_cnt = 0;
                s_dvd_tready = '0; s_dvs_tready = '0;
                continue;
            end
            for (int c = 0; c < 2; c++) begin
                if (running[c]) begin
                    if (lat_cnt[c] == 0) begin
                        m_dout_tvalid[c] = 1'b1;
                        m_dout_tdata[c*2*W +: 2*W] = ref_qr(c == 1, cap_dvd[c], cap_dvs[c]);
                        running[c] = 0;
                    end else begin
                        lat_cnt[c]--;
                    end
                end else if (got_dvd[c] && got_dvs[c]) begin
                    running[c] = 1; lat_cnt[c] = ip_lat;
                    got_dvd[c] = 0; got_dvs[c] = 0;
                end
            end
            if (ready_mode == 1) begin
                s_dvd_tready = {2{$urandom_range(0, 1) == 1}};
                s_dvs_tready = {2{$urandom_range(0, 1) == 1}};
            end else begin
                s_dvd_tready = (dvd_cnt >= dvd_delay) ? 2'b11 : 2'b00;
                s_dvs_tready = (dvs_cnt >= dvs_delay) ? 2'b11 : 2'b00;
            end
        end
    end

    // Presents one request; returns at posedge+1 of the accepting edge (first ISSUE cycle).
    task automatic issue(input logic sgn, input logic md, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        cur_signed = sgn;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_signed = sgn; req_mod = md; req_src1 = a; req_src2 = b;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready && k < 50);
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL req_accept: req_ready never rose within %0d cycles, required 1", k);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_src1 = $urandom; req_src2 = $urandom; req_mod = ~md;
    endtask

    task automatic get_resp(input string name, input logic [W-1:0] expv);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!resp_valid && k < 200);
        n_checks++;
        if (!resp_valid) begin
            n_fail++;
            $display("FAIL %s: resp_valid timeout, required resp_data=%h", name, expv);
        end else if (resp_data !== expv) begin
            n_fail++;
            $display("FAIL %s: resp_data=%h, required %h", name, resp_data, expv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_mod = 1'b0;
        req_src1 = '0; req_src2 = '0; resp_ready = 1'b1; cur_signed = 1'b0; expect_no_resp = 0;
        ready_mode = 0; dvd_delay = 0; dvs_delay = 0; ip_lat = 2;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({resp_valid, s_dvd_tvalid, s_dvs_tvalid, resp_data} !== '0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: resp_valid=%b dvd_tv=%b dvs_tv=%b resp_data=%h req_ready=%b, required 0/0/0/0/1",
                     resp_valid, s_dvd_tvalid, s_dvs_tvalid, resp_data, req_ready);
        end
        resetn = 1'b1;
    endtask

    task automatic test_div_basic();
        issue(1'b1, 1'b0, -32'sd7, 32'sd2);
        @(negedge clk);
        n_checks++;
        if (s_dvd_tvalid !== 2'b10 || s_dvs_tvalid !== 2'b10) begin
            n_fail++;
            $display("FAIL issue_tvalid: dvd=%b dvs=%b, required 10/10", s_dvd_tvalid, s_dvs_tvalid);
        end
        @(negedge clk);
        n_checks++;
        if (s_dvd_tvalid !== 2'b00 || s_dvs_tvalid !== 2'b00 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL one_cycle_issue: dvd=%b dvs=%b resp_valid=%b, required 00/00/0",
                     s_dvd_tvalid, s_dvs_tvalid, resp_valid);
        end
        get_resp("div_w_-7_2", 32'hFFFFFFFD);
    endtask

    task automatic test_split_handshake();
        int k;
        int dvd_hi;
        int dvs_hi;
        dvd_delay = 1; dvs_delay = 3;
        issue(1'b0, 1'b1, 32'hFFFFFFFF, 32'h10);
        k = 0; dvd_hi = 0; dvs_hi = 0;
        @(negedge clk);
        while ((s_dvd_tvalid | s_dvs_tvalid) != 0 && k < 20) begin
            dvd_hi += int'(s_dvd_tvalid[0]);
            dvs_hi += int'(s_dvs_tvalid[0]);
            k++;
            @(negedge clk);
        end
        n_checks++;
        if (dvd_hi != 2 || dvs_hi != 4) begin
            n_fail++;
            $display("FAIL split_tvalid_cycles: dvd=%0d dvs=%0d cycles, required 2 and 4", dvd_hi, dvs_hi);
        end
        get_resp("mod_wu_split", 32'h0000000F);
        dvd_delay = 0; dvs_delay = 0;
    endtask

    task automatic test_flush_issue();
        int k;
        dvd_delay = 0; dvs_delay = 4;
        issue(1'b1, 1'b0, 32'd50, 32'd5);
        @(posedge clk);
        #1;
        flush = 1'b1; expect_no_resp = 1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_dvs_tvalid !== 2'b10 || s_dvd_tvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL drain_tvalid: dvd=%b dvs=%b, required 00/10", s_dvd_tvalid, s_dvs_tvalid);
        end
        k = 0;
        while (!m_dout_tvalid[1] && k < 60) begin
            n_checks++;
            if (req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_req_ready: req_ready=%b before dout beat, required 0", req_ready);
            end
            k++;
            @(negedge clk);
        end
        n_checks++;
        if (!m_dout_tvalid[1] || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_beat: dout_seen=%b req_ready=%b, required 1/0", m_dout_tvalid[1], req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_return: req_ready=%b resp_valid=%b, required 1/0", req_ready, resp_valid);
        end
        repeat (3) @(negedge clk);
        expect_no_resp = 0; dvs_delay = 0;
    endtask

    task automatic test_flush_idle();
        @(posedge clk);
        #1;
        flush = 1'b1; req_valid = 1'b1; req_signed = 1'b1; req_src1 = 32'd9; req_src2 = 32'd3;
        cur_signed = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_ready: req_ready=%b, required 0", req_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ((s_dvd_tvalid | s_dvs_tvalid) !== 2'b00 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle_noaccept: dvd=%b dvs=%b req_ready=%b, required 00/00/1",
                     s_dvd_tvalid, s_dvs_tvalid, req_ready);
        end
    endtask

    task automatic test_flush_done();
        int k;
        resp_ready = 1'b0;
        issue(1'b1, 1'b0, 32'd20, 32'd4);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!resp_valid && k < 100);
        n_checks++;
        if (!resp_valid || resp_data !== 32'd5) begin
            n_fail++;
            $display("FAIL done_hold_data: resp_valid=%b resp_data=%h, required 1/%h", resp_valid, resp_data, 32'd5);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: resp_valid=%b while resp_ready=0, required 1", resp_valid);
        end
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done: resp_valid=%b req_ready=%b, required 0/1", resp_valid, req_ready);
        end
        resp_ready = 1'b1;
        issue(1'b1, 1'b0, 32'd10, 32'd3);
        get_resp("div_w_10_3", 32'd3);
    endtask

    task automatic test_async_reset();
        ip_lat = 10;
        issue(1'b1, 1'b1, -32'sd100, 32'sd7);
        @(negedge clk);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({resp_valid, resp_data, s_dvd_tvalid, s_dvs_tvalid, s_dvd_tdata, s_dvs_tdata} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: resp_valid=%b resp_data=%h tv=%b/%b tdata=%h/%h, required all 0",
                     resp_valid, resp_data, s_dvd_tvalid, s_dvs_tvalid, s_dvd_tdata, s_dvs_tdata);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        expect_no_resp = 1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || (s_dvd_tvalid | s_dvs_tvalid) !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: req_ready=%b tv=%b/%b, required 1/00/00",
                     req_ready, s_dvd_tvalid, s_dvs_tvalid);
        end
        repeat (15) @(negedge clk);
        expect_no_resp = 0; ip_lat = 2;
    endtask

    task automatic test_back_to_back();
        ip_lat = 1;
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        get_resp("b2b_div_w", 32'd14);
        issue(1'b1, 1'b1, 32'd100, 32'd7);
        get_resp("b2b_mod_w", 32'd2);
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        get_resp("b2b_div_wu", 32'd14);
        ip_lat = 2;
    endtask

    task automatic test_random();
        logic         sgn;
        logic         md;
        logic [W-1:0] a;
        logic [W-1:0] b;
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            sgn = $urandom_range(0, 1) == 1;
            md  = $urandom_range(0, 1) == 1;
            a   = $urandom;
            b   = (i % 3 == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
            if ($urandom_range(0, 3) == 0) a = -a;
            if (b == 0) b = 1;
            if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd2;
            ip_lat = $urandom_range(0, 4);
            issue(sgn, md, a, b);
            get_resp($sformatf("random_%0d", i), ref_result(sgn, md, a, b));
        end
        ready_mode = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_div_basic();
        test_split_handshake();
        test_flush_issue();
        test_flush_idle();
        test_flush_done();
        test_async_reset();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
